alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Shares one combinational ALU (driven by 5-bit alu_control codes) between two requesters,
//  e.g. the execute stage (req0) and the address/branch-target unit (req1).
//  - Round-robin arbitration with valid/ready handshakes.
//  - Optional lock so one requester can issue back-to-back ops.
//  - One registered response slot per requester; result latency is 1 cycle.
// PARAMETERS
//  XLEN    32  operand/result width
//  TAG_W   4   requester-supplied tag width, echoed with the result
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  reqN_valid   in   1      request valid, N=0,1
//  reqN_ready   out  1      request accepted this cycle (grant)
//  reqN_op      in   5      ALU control code
//  reqN_a       in   XLEN   operand A
//  reqN_b       in   XLEN   operand B
//  reqN_tag     in   TAG_W  tag
//  reqN_lock    in   1      keep grant on N after this op
//  alu_op_o     out  5      to ALU control input
//  alu_a_o      out  XLEN   to ALU operand A
//  alu_b_o      out  XLEN   to ALU operand B
//  alu_res_i    in   XLEN   ALU result, same cycle
//  alu_flag_i   in   1      ALU compare/branch flag, same cycle
//  rspN_valid   out  1      response valid
//  rspN_ready   in   1      response consumed
//  rspN_res     out  XLEN   registered result
//  rspN_flag    out  1      registered flag
//  rspN_tag     out  TAG_W  registered tag
// BEHAVIOUR
//  Reset values
//   - rspN_valid=0; rspN_res/flag/tag=0; state=ARB; rr_last=1, so req0 wins first.
//  Eligibility
//   - elig_N = reqN_valid && (!rspN_valid || rspN_ready): the slot is empty or drains this cycle.
//  Grant
//   - At most one grant per cycle; reqN_ready = grant_N, combinational.
//   - reqN_ready depends on reqN_valid; requesters must not gate valid on ready.
//   - State ARB: if exactly one elig_N, grant it. If both, grant the index != rr_last.
//   - State LOCKn: only requester n may be granted; the other stalls even if eligible.
//   - rr_last updates to the granted index on every grant and holds otherwise.
//  ALU drive
//   - When granted, alu_*_o = granted reqN_op/a/b.
//   - With no grant, alu_*_o = 0 (ADD 0+0), avoiding spurious toggling.
//  FSM (ARB, LOCK0, LOCK1)
//   - ARB   -> LOCKn : on grant_n && reqn_lock.
//   - LOCKn -> ARB   : on grant_n && !reqn_lock.
//   - LOCKn holds    : while no grant, including a stall on a full slot.
//   - A locked requester that drops valid keeps the lock; it is responsible for the release op.
//  Response slot N
//   - On grant_N: valid<=1, res<=alu_res_i, flag<=alu_flag_i, tag<=reqN_tag.
//   - Else if rspN_ready: valid<=0, data held.
//   - Else: hold.
//   - Drain and new grant in the same cycle load the new result; no bubble.
//   - While valid && !ready, res/flag/tag must not change.
//  Throughput
//   - Peak is 1 op/cycle total, 1 op/cycle per requester when it is alone.
//   - Result for an op accepted in cycle t appears on rspN_* at t+1.
//  Reset mid-operation
//   - Asynchronous: drops all pending responses and any lock immediately.
//   - In-flight work is discarded; requesters re-issue.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - ALU op code localparams: ADD 5'b00000, SUB 5'b00001, ... JAL 5'b10010.
//    - XLEN default.
//    - arbiter state encoding: ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2.
//  - Sub-module alu_rsp_slot: one response register with valid/ready and hold logic,
//    instantiated twice.
//  - Arbiter, FSM and ALU mux sit in alu_share_arb itself.
// TESTING (bench uses a behavioural ALU model on alu_*_o)
//  1. req0 only, op=ADD, a=5, b=7, tag=3
//     -> req0_ready=1 same cycle; next cycle rsp0_valid=1, res=12, tag=3.
//  2. Both valid every cycle, rsp ready=1, first ops after reset
//     -> grants 0,1,0,1,...; rsp0/rsp1 each valid every other cycle.
//  3. rsp0 full with rsp0_ready=0, both requesting
//     -> req0_ready=0; req1 granted each cycle; rsp0_res stable until ready.
//  4. req1 lock=1 for 3 ops then lock=0, req0 valid throughout
//     -> 4 consecutive req1 grants, then req0 granted; FSM back to ARB.
//  5. rsp0_valid=1, rsp0_ready=1, req0_valid=1, op=SUB, a=9, b=4
//     -> rsp0_valid stays 1, res=5 next cycle, no idle cycle.
//  6. rst_n low while in LOCK1 with both slots valid
//     -> rspN_valid=0 immediately; after release, req0 wins a tie.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// op codes, default widths and arbiter state encoding.
package alu_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_TAG_W = 4;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;
  localparam logic [4:0] ALU_BEQ  = 5'b01010;
  localparam logic [4:0] ALU_BNE  = 5'b01011;
  localparam logic [4:0] ALU_BLT  = 5'b01100;
  localparam logic [4:0] ALU_BGE  = 5'b01101;
  localparam logic [4:0] ALU_BLTU = 5'b01110;
  localparam logic [4:0] ALU_BGEU = 5'b01111;
  localparam logic [4:0] ALU_LUI  = 5'b10000;
  localparam logic [4:0] ALU_JALR = 5'b10001;
  localparam logic [4:0] ALU_JAL  = 5'b10010;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester's view of the shared ALU: request
// handshake plus its registered response slot.
interface alu_share_arb_if
  import alu_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W
);

  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             req_lock;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_res;
  logic             rsp_flag;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output req_tag, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_res,
    input  rsp_flag, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  req_tag, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_res,
    output rsp_flag, rsp_tag
  );

endinterface

// File: rtl/alu_rsp_slot.sv
// Single registered response entry; a load in the
// same cycle as a drain wins, so no bubble appears.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [XLEN-1:0]  d_res,
  input  logic             d_flag,
  input  logic [TAG_W-1:0] d_tag,
  output logic             valid,
  output logic [XLEN-1:0]  res,
  output logic             flag,
  output logic [TAG_W-1:0] tag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      res   <= '0;
      flag  <= 1'b0;
      tag   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      res   <= d_res;
      flag  <= d_flag;
      tag   <= d_tag;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU
// between two requesters, with optional grant lock.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_arb_if.slave  p0,
  alu_share_arb_if.slave  p1,
  output logic [4:0]      alu_op_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic            alu_flag_i
);

  arb_state_e state, state_nxt;
  logic rr_last;
  logic elig0, elig1;
  logic grant0, grant1;

  assign elig0 = p0.req_valid && (!p0.rsp_valid || p0.rsp_ready);
  assign elig1 = p1.req_valid && (!p1.rsp_valid || p1.rsp_ready);

  assign p0.req_ready = grant0;
  assign p1.req_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      rr_last <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant0)      rr_last <= 1'b0;
      else if (grant1) rr_last <= 1'b1;
    end
  end

  // On a tie the requester that did not win last goes next
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    unique case (state)
      ARB: begin
        if (elig0 && elig1) begin
          grant0 = rr_last;
          grant1 = !rr_last;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
        if (grant0 && p0.req_lock)
          state_nxt = LOCK0;
        else if (grant1 && p1.req_lock)
          state_nxt = LOCK1;
      end
      LOCK0: begin
        grant0 = elig0;
        if (grant0 && !p0.req_lock)
          state_nxt = ARB;
      end
      LOCK1: begin
        grant1 = elig1;
        if (grant1 && !p1.req_lock)
          state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    alu_op_o = ALU_ADD;
    alu_a_o  = '0;
    alu_b_o  = '0;
    unique case (1'b1)
      grant0: begin
        alu_op_o = p0.req_op;
        alu_a_o  = p0.req_a;
        alu_b_o  = p0.req_b;
      end
      grant1: begin
        alu_op_o = p1.req_op;
        alu_a_o  = p1.req_a;
        alu_b_o  = p1.req_b;
      end
      default: ;
    endcase
  end

  alu_rsp_slot #(.XLEN(XLEN), .TAG_W(TAG_W)) u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant0),
    .drain (p0.rsp_ready),
    .d_res (alu_res_i),
    .d_flag(alu_flag_i),
    .d_tag (p0.req_tag),
    .valid (p0.rsp_valid),
    .res   (p0.rsp_res),
    .flag  (p0.rsp_flag),
    .tag   (p0.rsp_tag)
  );

  alu_rsp_slot #(.XLEN(XLEN), .TAG_W(TAG_W)) u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant1),
    .drain (p1.rsp_ready),
    .d_res (alu_res_i),
    .d_flag(alu_flag_i),
    .d_tag (p1.req_tag),
    .valid (p1.rsp_valid),
    .res   (p1.rsp_res),
    .flag  (p1.rsp_flag),
    .tag   (p1.rsp_tag)
  );

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed scoreboard bench for alu_share_arb with a
// behavioural ALU hung off the alu_* outputs.
module tb_alu_share_arb;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        flag;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_flag;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   passes = 0;
  int   fails = 0;

  alu_share_arb_if #(.XLEN(32), .TAG_W(4)) i0 ();
  alu_share_arb_if #(.XLEN(32), .TAG_W(4)) i1 ();

  alu_share_arb #(.XLEN(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0        (i0),
    .p1        (i1),
    .alu_op_o  (alu_op),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b),
    .alu_res_i (alu_res),
    .alu_flag_i(alu_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_f(
    input logic [4:0] op, input logic [31:0] a, b);
    logic [31:0] r;
    logic        f;
    r = '0;
    f = 1'b0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLT: begin
        f = $signed(a) < $signed(b);
        r = {31'b0, f};
      end
      ALU_BEQ: f = (a == b);
      default: r = '0;
    endcase
    return {f, r};
  endfunction

  always_comb {alu_flag, alu_res} = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [4:0] op,
                      input logic [31:0] a, b,
                      input logic [3:0] tg, input logic lk);
    i0.req_valid = v;  i0.req_op = op;
    i0.req_a = a;      i0.req_b = b;
    i0.req_tag = tg;   i0.req_lock = lk;
  endtask

  task automatic set1(input logic v, input logic [4:0] op,
                      input logic [31:0] a, b,
                      input logic [3:0] tg, input logic lk);
    i1.req_valid = v;  i1.req_op = op;
    i1.req_a = a;      i1.req_b = b;
    i1.req_tag = tg;   i1.req_lock = lk;
  endtask

  task automatic idle();
    set0(0, ALU_ADD, 0, 0, 0, 0);
    set1(0, ALU_ADD, 0, 0, 0, 0);
  endtask

  function automatic exp_t mk(input logic [4:0] op,
                              input logic [31:0] a, b,
                              input logic [3:0] tg);
    exp_t e;
    logic [32:0] fr;
    fr = alu_f(op, a, b);
    e.res  = fr[31:0];
    e.flag = fr[32];
    e.tag  = tg;
    return e;
  endfunction

  // one cycle: inputs set at negedge, checks at +1
  task automatic step(input logic r0, r1, eg0, eg1,
                      input string nm);
    exp_t e;
    i0.rsp_ready = r0;
    i1.rsp_ready = r1;
    #1;
    chk({nm, "_g0"}, 32'(i0.req_ready), 32'(eg0));
    chk({nm, "_g1"}, 32'(i1.req_ready), 32'(eg1));
    chk({nm, "_v0"}, 32'(i0.rsp_valid), 32'(q0.size() != 0));
    chk({nm, "_v1"}, 32'(i1.rsp_valid), 32'(q1.size() != 0));
    if (q0.size() != 0 && i0.rsp_valid) begin
      e = q0[0];
      chk({nm, "_res0"}, i0.rsp_res, e.res);
      chk({nm, "_flg0"}, 32'(i0.rsp_flag), 32'(e.flag));
      chk({nm, "_tag0"}, 32'(i0.rsp_tag), 32'(e.tag));
      if (r0) void'(q0.pop_front());
    end
    if (q1.size() != 0 && i1.rsp_valid) begin
      e = q1[0];
      chk({nm, "_res1"}, i1.rsp_res, e.res);
      chk({nm, "_flg1"}, 32'(i1.rsp_flag), 32'(e.flag));
      chk({nm, "_tag1"}, 32'(i1.rsp_tag), 32'(e.tag));
      if (r1) void'(q1.pop_front());
    end
    if (eg0) begin
      chk({nm, "_aluop"}, 32'(alu_op), 32'(i0.req_op));
      q0.push_back(mk(i0.req_op, i0.req_a, i0.req_b, i0.req_tag));
    end
    if (eg1) begin
      chk({nm, "_aluop"}, 32'(alu_op), 32'(i1.req_op));
      q1.push_back(mk(i1.req_op, i1.req_a, i1.req_b, i1.req_tag));
    end
    if (!eg0 && !eg1)
      chk({nm, "_aluidle"}, {27'b0, alu_op} | alu_a | alu_b, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    idle();
    i0.rsp_ready = 1'b0;
    i1.rsp_ready = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_v0"}, 32'(i0.rsp_valid), 32'd0);
    chk({nm, "_v1"}, 32'(i1.rsp_valid), 32'd0);
    chk({nm, "_res0"}, i0.rsp_res, 32'd0);
    chk({nm, "_tag1"}, 32'(i1.rsp_tag), 32'd0);
    chk({nm, "_flg0"}, 32'(i0.rsp_flag), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    i0.rsp_ready = 1'b0;
    i1.rsp_ready = 1'b0;
    @(negedge clk);
    do_reset("rst");

    set0(1, ALU_ADD, 5, 7, 3, 0);
    step(1, 1, 1, 0, "t1_acc");
    idle();
    step(1, 1, 0, 0, "t1_rsp");

    do_reset("rst2");
    for (int i = 0; i < 6; i++) begin
      set0(1, ALU_ADD, i, 10, 4'(i), 0);
      set1(1, ALU_SUB, 100, i, 4'(i + 8), 0);
      step(1, 1, (i % 2) == 0, (i % 2) == 1, "t2_rr");
    end
    idle();
    step(1, 1, 0, 0, "t2_drain");

    set0(1, ALU_XOR, 32'hF0, 32'h0F, 5, 0);
    set1(1, ALU_ADD, 1, 2, 6, 0);
    step(0, 1, 1, 0, "t3_first");
    for (int k = 0; k < 3; k++) begin
      set0(1, ALU_OR, k, 32'h100, 7, 0);
      set1(1, ALU_SLT, k, 1, 4'(k), 0);
      step(0, 1, 0, 1, "t3_stall");
    end
    step(1, 1, 1, 0, "t3_release");
    idle();
    step(1, 1, 0, 0, "t3_drain");

    for (int k = 0; k < 4; k++) begin
      set0(1, ALU_ADD, k, 1, 1, 0);
      set1(1, ALU_SUB, 50, k, 4'(k), k < 3);
      step(1, 1, 0, 1, "t4_lock");
    end
    chk("t4_state", 32'(dut.state), 32'(ARB));
    step(1, 1, 1, 0, "t4_rr");
    step(1, 1, 0, 1, "t4_alt");
    idle();
    step(1, 1, 0, 0, "t4_drain");

    set0(1, ALU_ADD, 1, 1, 1, 0);
    step(1, 1, 1, 0, "t5_fill");
    set0(1, ALU_SUB, 9, 4, 2, 0);
    step(1, 1, 1, 0, "t5_b2b");
    idle();
    step(1, 1, 0, 0, "t5_out");

    set0(1, ALU_AND, 32'hFF, 32'h3C, 9, 0);
    step(0, 1, 1, 0, "t6_fill0");
    set0(0, ALU_ADD, 0, 0, 0, 0);
    set1(1, ALU_BEQ, 4, 4, 10, 1);
    step(0, 0, 0, 1, "t6_lock");
    chk("t6_lk", 32'(dut.state), 32'(LOCK1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rv0", 32'(i0.rsp_valid), 32'd0);
    chk("t6_rv1", 32'(i1.rsp_valid), 32'd0);
    chk("t6_rst", 32'(dut.state), 32'(ARB));
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set0(1, ALU_ADD, 3, 4, 11, 0);
    set1(1, ALU_ADD, 5, 6, 12, 0);
    step(1, 1, 1, 0, "t6_tie");
    idle();
    step(1, 1, 0, 0, "t6_drain");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
